fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_arbiter_if.sv | 47 ++++
 rtl/fb_fill_engine.sv | 77 +++++++
 rtl/fb_arbiter.sv | 75 +++++++
 tb/tb_fb_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared encodings and defaults for the frame-buffer arbiter
package fb_pkg;

   localparam int FB_ADDR_BITS = 16;
   localparam int FB_DATA_W    = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   // Owner of the read issued last cycle; selects which requester sees bram_rdata.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_HOST = 2'd2
   } owner_tag_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - display, host, fill and BRAM signal bundle for fb_arbiter
interface fb_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_BITS = FB_ADDR_BITS,
   parameter int DATA_W    = FB_DATA_W
) ();

   logic                 disp_req;
   logic [ADDR_BITS-1:0] disp_addr;
   logic                 disp_rvalid;
   logic [DATA_W-1:0]    disp_rdata;

   logic                 host_valid;
   logic                 host_ready;
   logic                 host_we;
   logic [ADDR_BITS-1:0] host_addr;
   logic [DATA_W-1:0]    host_wdata;
   logic                 host_rvalid;
   logic [DATA_W-1:0]    host_rdata;

   logic                 fill_start;
   logic [DATA_W-1:0]    fill_value;
   logic                 fill_busy;
   logic                 fill_done;

   logic                 bram_en;
   logic                 bram_we;
   logic [ADDR_BITS-1:0] bram_addr;
   logic [DATA_W-1:0]    bram_wdata;
   logic [DATA_W-1:0]    bram_rdata;

   modport slave (
      input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
             fill_start, fill_value, bram_rdata,
      output disp_rvalid, disp_rdata, host_ready, host_rvalid, host_rdata,
             fill_busy, fill_done, bram_en, bram_we, bram_addr, bram_wdata
   );

   modport master (
      output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
             fill_start, fill_value, bram_rdata,
      input  disp_rvalid, disp_rdata, host_ready, host_rvalid, host_rdata,
             fill_busy, fill_done, bram_en, bram_we, bram_addr, bram_wdata
   );

endinterface

// File: rtl/fb_fill_engine.sv
// rtl/fb_fill_engine.sv - sequential whole-buffer fill with stall and done pulse
module fb_fill_engine
   import fb_pkg::*;
#(
   parameter int ADDR_BITS = FB_ADDR_BITS,
   parameter int DATA_W    = FB_DATA_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_W-1:0]    value,
   input  logic                 stall,
   output logic                 busy,
   output logic                 done,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [DATA_W-1:0]    wr_data
);

   fill_state_e          state_q, state_d;
   logic [ADDR_BITS:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]    val_q, val_d;
   logic                 done_q, done_d;
   logic                 last;

   // Terminal write is the all-ones address, so the counter never wraps into address 0.
   assign last = &cnt_q[ADDR_BITS-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               cnt_d   = '0;
               val_d   = value;
            end
         end
         ST_FILL: begin
            if (!stall) begin
               wr_en = 1'b1;
               if (last) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q == ST_FILL);
   assign done    = done_q;
   assign wr_addr = cnt_q[ADDR_BITS-1:0];
   assign wr_data = val_q;

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port frame-buffer arbiter: display > fill > host
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_BITS = FB_ADDR_BITS,
   parameter int DATA_W    = FB_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   fb_arbiter_if.slave  bus
);

   logic                 fill_busy;
   logic                 fill_wr_en;
   logic [ADDR_BITS-1:0] fill_wr_addr;
   logic [DATA_W-1:0]    fill_wr_data;
   logic                 host_accept;
   owner_tag_e           tag_q, tag_d;

   fb_fill_engine #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_W    (DATA_W)
   ) u_fill (
      .clk     (clk),
      .reset   (reset),
      .start   (bus.fill_start),
      .value   (bus.fill_value),
      .stall   (bus.disp_req),
      .busy    (fill_busy),
      .done    (bus.fill_done),
      .wr_en   (fill_wr_en),
      .wr_addr (fill_wr_addr),
      .wr_data (fill_wr_data)
   );

   assign bus.fill_busy  = fill_busy;
   assign bus.host_ready = !bus.disp_req && !fill_busy;
   assign host_accept    = bus.host_valid && bus.host_ready;

   always_comb begin
      bus.bram_en    = 1'b0;
      bus.bram_we    = 1'b0;
      bus.bram_addr  = '0;
      bus.bram_wdata = '0;
      tag_d          = TAG_NONE;
      if (bus.disp_req) begin
         bus.bram_en   = 1'b1;
         bus.bram_addr = bus.disp_addr;
         tag_d         = TAG_DISP;
      end else if (fill_wr_en) begin
         bus.bram_en    = 1'b1;
         bus.bram_we    = 1'b1;
         bus.bram_addr  = fill_wr_addr;
         bus.bram_wdata = fill_wr_data;
      end else if (host_accept) begin
         bus.bram_en    = 1'b1;
         bus.bram_we    = bus.host_we;
         bus.bram_addr  = bus.host_addr;
         bus.bram_wdata = bus.host_wdata;
         tag_d          = bus.host_we ? TAG_NONE : TAG_HOST;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tag_q <= TAG_NONE;
      else        tag_q <= tag_d;
   end

   // Read data is gated by the tag so an idle requester always sees zero.
   assign bus.disp_rvalid = (tag_q == TAG_DISP);
   assign bus.host_rvalid = (tag_q == TAG_HOST);
   assign bus.disp_rdata  = bus.disp_rvalid ? bus.bram_rdata : '0;
   assign bus.host_rdata  = bus.host_rvalid ? bus.bram_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter
module tb_fb_arbiter;
   import fb_pkg::*;

   localparam int AB  = 4;
   localparam int DW  = 8;
   localparam int BAB = 16;

   typedef struct {
      int            stamp;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fb_arbiter_if #(.ADDR_BITS(AB),  .DATA_W(DW)) bus ();
   fb_arbiter_if #(.ADDR_BITS(BAB), .DATA_W(DW)) bbus ();

   fb_arbiter #(.ADDR_BITS(AB),  .DATA_W(DW)) dut     (.clk(clk), .reset(reset), .bus(bus));
   fb_arbiter #(.ADDR_BITS(BAB), .DATA_W(DW)) dut_big (.clk(clk), .reset(reset), .bus(bbus));

   logic [DW-1:0] mem  [0:(1<<AB)-1];
   logic [DW-1:0] bmem [0:(1<<BAB)-1];

   always @(posedge clk) begin
      if (bus.bram_en) begin
         if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
         else             bus.bram_rdata     <= mem[bus.bram_addr];
      end
      if (bbus.bram_en) begin
         if (bbus.bram_we) bmem[bbus.bram_addr] <= bbus.bram_wdata;
         else              bbus.bram_rdata      <= bmem[bbus.bram_addr];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   logic [AB-1:0] wlog [$];
   always @(posedge clk)
      if (reset && bus.bram_en && bus.bram_we) wlog.push_back(bus.bram_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   exp_t disp_q [$];
   exp_t host_q [$];

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (bus.disp_rvalid && bus.host_rvalid) chk("both_rvalid", 1, 0);
         if (bus.disp_rvalid || (disp_q.size() > 0 && disp_q[0].stamp <= cyc_n)) begin
            if (disp_q.size() == 0) chk("disp_unexpected", 1, 0);
            else begin
               e = disp_q.pop_front();
               chk("disp_rvalid", bus.disp_rvalid, 1);
               chk("disp_latency", cyc_n, e.stamp);
               chk("disp_rdata", bus.disp_rdata, e.data);
            end
         end
         if (bus.host_rvalid || (host_q.size() > 0 && host_q[0].stamp <= cyc_n)) begin
            if (host_q.size() == 0) chk("host_unexpected", 1, 0);
            else begin
               e = host_q.pop_front();
               chk("host_rvalid", bus.host_rvalid, 1);
               chk("host_latency", cyc_n, e.stamp);
               chk("host_rdata", bus.host_rdata, e.data);
            end
         end
      end
   end

   logic [DW-1:0] ref_mem [0:(1<<AB)-1];
   bit            m_busy = 0;
   bit            m_done = 0;
   logic [AB-1:0] m_cnt  = '0;
   logic [DW-1:0] m_val  = '0;
   int            done_cycle = -1;
   int            last_cyc = 0;

   task automatic cyc(input bit d, input logic [AB-1:0] da, input bit hv, input bit hwe,
                      input logic [AB-1:0] ha, input logic [DW-1:0] hwd,
                      input bit fs, input logic [DW-1:0] fv);
      bit            old_busy, exp_en, exp_we;
      logic [AB-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      exp_t          e;
      @(negedge clk);
      last_cyc = cyc_n;
      bus.disp_req = d;   bus.disp_addr = da;
      bus.host_valid = hv; bus.host_we = hwe; bus.host_addr = ha; bus.host_wdata = hwd;
      bus.fill_start = fs; bus.fill_value = fv;
      #1;
      chk("fill_busy", bus.fill_busy, m_busy);
      chk("fill_done", bus.fill_done, m_done);
      if (bus.fill_done) done_cycle = cyc_n;
      m_done = 0;
      chk("host_ready", bus.host_ready, !d && !m_busy);
      old_busy = m_busy;
      exp_en = 0; exp_we = 0; exp_addr = '0; exp_data = '0;
      if (d) begin
         exp_en = 1; exp_addr = da;
         e.stamp = cyc_n + 1; e.data = ref_mem[da]; disp_q.push_back(e);
      end else if (m_busy) begin
         exp_en = 1; exp_we = 1; exp_addr = m_cnt; exp_data = m_val;
         ref_mem[m_cnt] = m_val;
         if (m_cnt == '1) begin m_busy = 0; m_done = 1; end
         else m_cnt = m_cnt + 1'b1;
      end else if (hv) begin
         exp_en = 1; exp_we = hwe; exp_addr = ha; exp_data = hwd;
         if (hwe) ref_mem[ha] = hwd;
         else begin e.stamp = cyc_n + 1; e.data = ref_mem[ha]; host_q.push_back(e); end
      end
      if (fs && !old_busy) begin m_busy = 1; m_cnt = '0; m_val = fv; end
      chk("bram_en", bus.bram_en, exp_en);
      chk("bram_we", bus.bram_we, exp_we);
      if (exp_en) chk("bram_addr", bus.bram_addr, exp_addr);
      if (exp_we) chk("bram_wdata", bus.bram_wdata, exp_data);
   endtask

   task automatic idle();
      cyc(0, '0, 0, 0, '0, '0, 0, '0);
   endtask

   initial begin
      int start, stalls;
      bus.disp_req = 0; bus.disp_addr = '0; bus.host_valid = 0; bus.host_we = 0;
      bus.host_addr = '0; bus.host_wdata = '0; bus.fill_start = 0; bus.fill_value = '0;
      bus.bram_rdata = '0;
      bbus.disp_req = 0; bbus.disp_addr = '0; bbus.host_valid = 0; bbus.host_we = 0;
      bbus.host_addr = '0; bbus.host_wdata = '0; bbus.fill_start = 0; bbus.fill_value = '0;
      bbus.bram_rdata = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_disp_rvalid", bus.disp_rvalid, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_fill_busy", bus.fill_busy, 0);
      chk("rst_fill_done", bus.fill_done, 0);
      chk("rst_host_ready", bus.host_ready, 1);
      chk("rst_bram_en", bus.bram_en, 0);
      chk("rst_disp_rdata", bus.disp_rdata, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      @(negedge clk); reset = 1;

      // host write then read at 0x1234 on the 16-bit instance
      @(negedge clk);
      bbus.host_valid = 1; bbus.host_we = 1; bbus.host_addr = 16'h1234; bbus.host_wdata = 8'hA5;
      #1;
      chk("big_ready", bbus.host_ready, 1);
      chk("big_wr_we", bbus.bram_we, 1);
      chk("big_wr_addr", bbus.bram_addr, 32'h1234);
      @(negedge clk); bbus.host_we = 0; #1;
      chk("big_rd_en", bbus.bram_en, 1);
      chk("big_rd_we", bbus.bram_we, 0);
      chk("big_no_rvalid_yet", bbus.host_rvalid, 0);
      @(negedge clk); bbus.host_valid = 0; #1;
      chk("big_rvalid", bbus.host_rvalid, 1);
      chk("big_rdata", bbus.host_rdata, 32'hA5);
      @(negedge clk); #1;
      chk("big_rvalid_drop", bbus.host_rvalid, 0);

      // basic host traffic and a blocked host request under disp_req
      cyc(0, '0, 1, 1, 4'd3, 8'h11, 0, '0);
      cyc(0, '0, 1, 1, 4'd5, 8'h22, 0, '0);
      cyc(0, '0, 1, 0, 4'd3, '0, 0, '0);
      cyc(0, '0, 1, 0, 4'd5, '0, 0, '0);
      cyc(1, 4'd5, 1, 0, 4'd3, '0, 0, '0);
      idle(); idle();

      // fill 0x3C with no display traffic
      wlog.delete();
      cyc(0, '0, 0, 0, '0, '0, 1, 8'h3C);
      start = last_cyc;
      repeat (19) idle();
      chk("fill1_done_cycle", done_cycle - start, 17);
      chk("fill1_writes", wlog.size(), 16);
      for (int i = 0; i < 16 && i < wlog.size(); i++) chk("fill1_addr", wlog[i], i);
      for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, AB'(i), '0, 0, '0);

      // distinct contents, then display every 4th cycle against continuous host reads
      for (int i = 0; i < 16; i++) cyc(0, '0, 1, 1, AB'(i), DW'(i * 17 + 1), 0, '0);
      for (int i = 0; i < 16; i++)
         cyc(i % 4 == 0, AB'(i), 1, 0, AB'(i + 1), '0, 0, '0);
      idle(); idle();

      // fill 0x5A with display stalls and an ignored restart mid-fill
      wlog.delete();
      stalls = 0;
      cyc(0, '0, 0, 0, '0, '0, 1, 8'h5A);
      start = last_cyc;
      for (int i = 1; i < 60 && done_cycle <= start; i++) begin
         if ((i % 4 == 3) && m_busy) stalls++;
         cyc(i % 4 == 3, AB'(i), 1, 0, AB'(i), '0, i == 9, 8'hFF);
      end
      chk("fill2_done_seen", done_cycle > start, 1);
      chk("fill2_done_cycle", done_cycle - start, 17 + stalls);
      chk("fill2_writes", wlog.size(), 16);
      for (int i = 0; i < 16 && i < wlog.size(); i++) chk("fill2_addr", wlog[i], i);
      for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, AB'(i), '0, 0, '0);

      // fill_start with a host write in the same cycle
      cyc(0, '0, 1, 1, 4'd9, 8'h77, 1, 8'h66);
      repeat (18) idle();
      cyc(0, '0, 1, 0, 4'd9, '0, 0, '0);
      cyc(0, '0, 1, 0, 4'd8, '0, 0, '0);
      idle(); idle();

      // reset when the fill reaches address 7
      cyc(0, '0, 0, 0, '0, '0, 1, 8'h99);
      for (int g = 0; g < 20 && m_cnt != 4'd7; g++) idle();
      chk("abort_at_7", m_cnt, 7);
      @(negedge clk);
      reset = 0;
      #1;
      chk("abort_busy", bus.fill_busy, 0);
      chk("abort_done", bus.fill_done, 0);
      chk("abort_bram_en", bus.bram_en, 0);
      m_busy = 0; m_done = 0;
      repeat (2) begin @(negedge clk); #1; chk("abort_done_hold", bus.fill_done, 0); end
      @(negedge clk); reset = 1; #1;
      chk("abort_ready", bus.host_ready, 1);
      repeat (20) idle();
      cyc(0, '0, 1, 1, 4'd2, 8'hC3, 0, '0);
      cyc(0, '0, 1, 0, 4'd2, '0, 0, '0);
      idle(); idle(); idle();

      chk("disp_q_empty", disp_q.size(), 0);
      chk("host_q_empty", host_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
